// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: multiplies resolved in one cycle at accept.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic [2*XLEN-1:0]  acc, acc_nxt;
    logic [XLEN-1:0]    opnd;
    logic [2:0]         op_q;
    logic               neg_q;

    logic               s1_signed, s2_signed, neg1, neg2, req_div;
    logic               div_zero, div_ovf, go_done;
    logic [XLEN-1:0]    mag1, mag2, special_data, accept_data;

    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_shift;
    logic               div_ge;
    logic [XLEN-1:0]    div_sub;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix, rem_fix, finish_data;

    // Request decode: signedness, magnitudes and divide special cases
    always_comb begin
        s1_signed = 1'b0;
        s2_signed = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                s1_signed = 1'b1;
                s2_signed = 1'b1;
            end
            3'b010:  s1_signed = 1'b1;
            default: ;
        endcase
        req_div  = req_funct3[2];
        neg1     = s1_signed & req_src1[XLEN-1];
        neg2     = s2_signed & req_src2[XLEN-1];
        mag1     = neg1 ? -req_src1 : req_src1;
        mag2     = neg2 ? -req_src2 : req_src2;
        div_zero = req_div && (req_src2 == '0);
        div_ovf  = req_div && !req_funct3[0] &&
                   (req_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_src2 == '1);
        if (div_zero)
            special_data = req_funct3[1] ? req_src1 : '1;
        else
            special_data = req_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_data;

    // Truncated two's-complement product: high half is exact for every mul variant
    always_comb begin
        fast_a      = {{XLEN{neg1}}, req_src1};
        fast_b      = {{XLEN{neg2}}, req_src2};
        fast_prod   = fast_a * fast_b;
        fast_data   = (req_funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                 : fast_prod[2*XLEN-1:XLEN];
        go_done     = div_zero | div_ovf | ~req_div;
        accept_data = req_div ? special_data : fast_data;
    end
`else
    always_comb begin
        go_done     = div_zero | div_ovf;
        accept_data = special_data;
    end
`endif

    // One iteration: acc = {hi, lo}; mul consumes lo LSB-first, div keeps {rem, quo}
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, opnd};
        div_sub   = div_shift[XLEN-1:0] - opnd;
        if (op_q[2])
            acc_nxt = div_ge ? {div_sub, acc[XLEN-2:0], 1'b1}
                             : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end

    always_comb begin
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_fix  = neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        if (op_q[2])
            finish_data = op_q[1] ? rem_fix : quo_fix;
        else
            finish_data = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                               : prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = go_done ? DONE : CALC;
            CALC:    if (count == LAST) state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            opnd      <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            count     <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q  <= req_funct3;
                    count <= '0;
                    // Remainder follows the dividend; everything else follows sign XOR
                    neg_q <= (req_div & req_funct3[1]) ? neg1 : (neg1 ^ neg2);
                    if (req_div) begin
                        acc  <= {{XLEN{1'b0}}, mag1};
                        opnd <= mag2;
                    end else begin
                        acc  <= {{XLEN{1'b0}}, mag2};
                        opnd <= mag1;
                    end
                    if (go_done)
                        resp_data <= accept_data;
                end
                CALC: begin
                    acc   <= acc_nxt;
                    count <= count + 1'b1;
                    if (count == LAST)
                        resp_data <= finish_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, scoreboard queue, latency,
// backpressure and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
            if (b == 32'h0) return 1;
            if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    function automatic void add(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Drive a request, hold until accepted, then scramble inputs to prove they were latched
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
        int guard = 0;
        req_funct3 = f3; req_src1 = a; req_src2 = b; req_valid = 1'b1;
        while (!req_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready_wait", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom);
        req_src1   = $urandom;
        req_src2   = $urandom;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input string name, input int lat_exp);
        int lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(lat_exp));
    endtask

    task automatic take(input string name);
        logic [31:0] e;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = 'x;
        resp_ready = 1'b1;
        check(name, resp_data, e);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({name, "_drop"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_funct3 = '0; req_src1 = '0; req_src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        rst = 1'b0;

        add(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        add(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        add(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        add(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        add(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        add(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        add(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        add(3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        add(3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        add(3'b011, 32'h8000_0000, 32'd2,          32'h0000_0001);
        add(3'b010, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF);
        add(3'b010, 32'd2,          32'hFFFF_FFFF, 32'h0000_0001);
        add(3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD);
        add(3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF);
        add(3'b101, 32'd100,        32'd7,          32'd14);
        add(3'b111, 32'd100,        32'd7,          32'd2);
        add(3'b100, 32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD);
        add(3'b110, 32'd20,         32'hFFFF_FFFA, 32'd2);
        add(3'b100, 32'h8000_0000, 32'd2,          32'hC000_0000);
        add(3'b100, 32'h8000_0000, 32'd3,          32'hD555_5556);
        add(3'b110, 32'h8000_0000, 32'd3,          32'hFFFF_FFFE);
        add(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        add(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        add(3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F);
        add(3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF);
        add(3'b110, 32'd5,          32'd0,          32'd5);
        add(3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF);
        add(3'b111, 32'd5,          32'd0,          32'd5);
        add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        add(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_resp($sformatf("vec%0d", i), exp_lat(vecs[i].f3, vecs[i].a, vecs[i].b));
            take($sformatf("vec%0d", i));
        end

        // Backpressure: result held, no new accept while DONE
        send(3'b101, 32'd100, 32'd7, 32'd14);
        wait_resp("bp", 33);
        req_funct3 = 3'b000; req_src1 = 32'd3; req_src2 = 32'd3; req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp_data", resp_data, 32'd14);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        check("bp_take", resp_data, exp_q.size() != 0 ? exp_q.pop_front() : 32'hx);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_idle_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_src1  = $urandom;
        exp_q.push_back(32'd9);
        wait_resp("bp_next", exp_lat(3'b000, 32'd3, 32'd3));
        take("bp_next");

        // Reset while CALC at count 10 discards the operation
        send(3'b101, 32'd1000, 32'd7, 32'd142);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
        repeat (35) @(posedge clk);
        #1;
        check("rst_mid_quiet", {31'b0, resp_valid}, 32'd0);
        send(3'b101, 32'd9, 32'd3, 32'd3);
        wait_resp("post_rst", 33);
        take("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
